etapa_decodificacion: RTL and testbench
=======================================

// Module: etapa_decodificacion
// PURPOSE
//  Decode/operand-fetch stage between instruction fetch and execute. Accepts one RV32I instruction per
//  handshake, drives the RegisterFile read addresses, applies the write-back bypass, builds the immediate.
//  Holds the result in a one-entry ID/EX pipeline register with valid/ready flow control, flush, and a load-use stall.
// PARAMETERS
//  ANCHO      32  datapath / instruction width (RV32I, fixed 32 in this release)
//  ANCHO_DIR   5  register address width (32 architectural registers)
// PORTS
//  clk          in   1          clock, rising edge
//  rst_n        in   1          reset, asynchronous, active-low
//  in_valid     in   1          fetch presents an instruction
//  in_ready     out  1          stage accepts the instruction this cycle
//  in_instr     in   ANCHO      instruction word
//  in_pc        in   ANCHO      PC of in_instr
//  flush        in   1          discard the held instruction and the presented instruction (branch taken)
//  DL1, DL2     out  ANCHO_DIR  RegisterFile read addresses = in_instr[19:15], in_instr[24:20]
//  Op1, Op2     in   ANCHO      RegisterFile read data (combinational)
//  wb_we        in   1          write-back enable (same signal as the RegisterFile WE)
//  wb_de        in   ANCHO_DIR  write-back address
//  wb_dato      in   ANCHO      write-back data
//  ex_load      in   1          instruction currently in execute is a load
//  ex_rd        in   ANCHO_DIR  destination of that load
//  out_valid    out  1          ID/EX register holds a valid instruction
//  out_ready    in   1          execute consumes it this cycle
//  out_op1, out_op2 out ANCHO   resolved operands
//  out_imm      out  ANCHO      sign-extended immediate
//  out_rd       out  ANCHO_DIR  destination register
//  out_rd_we    out  1          instruction writes rd (rd != 0 and type R/I/U/J/load)
//  out_opcode   out  7          opcode[6:0]
//  out_funct3   out  3          funct3
//  out_funct7b5 out  1          instr[30]
//  out_pc       out  ANCHO      PC
// BEHAVIOUR
//  - Reset: out_valid=0, every out_* data field=0; in_ready follows the combinational rule below.
//  - Latency: 1 cycle, in-accept edge -> out_valid. Throughput: 1 instr/cycle when out_ready=1.
//  - hazard = ex_load & ex_rd!=0 & ((usa_rs1 & rs1==ex_rd) | (usa_rs2 & rs2==ex_rd)).
//    usa_rs1 = false for LUI, AUIPC, JAL; usa_rs2 = true only for R, S, B types.
//  - in_ready = (!out_valid | out_ready) & !hazard. Accept = in_valid & in_ready.
//  - Operand resolution per source: rs==0 -> 0 (x0 forced here, not in the RegisterFile);
//    else wb_we & wb_de==rs -> wb_dato (bypass); else Op1/Op2.
//  - Immediate by opcode: I (OP-IMM, LOAD, JALR), S, B (bit0=0), U (low 12 bits=0), J (bit0=0);
//    R type -> 0. Unknown opcode -> imm 0, out_rd_we 0; instruction still passed (execute traps).
//  - Register update each edge, priority order:
//    1) flush: out_valid<=0; presented instruction dropped even if in_valid (in_ready value ignored).
//    2) accept: load all out_* fields, out_valid<=1.
//    3) out_ready & out_valid, no accept: out_valid<=0 (bubble); data fields hold.
//    4) otherwise hold everything.
//  - Stall: out_valid & !out_ready -> all outputs stable, in_ready=0.
//  - hazard with out_ready=1 -> bubble inserted (case 3); instruction re-presented next cycle,
//    the load is then in memory/write-back, and the bypass or RegisterFile supplies the value.
//  - Asynchronous reset mid-operation: out_valid clears immediately; no partial capture.
// STRUCTURE
//  - Package isa_pkg: opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC),
//    the enum tipo_inm_t {INM_I, INM_S, INM_B, INM_U, INM_J, INM_NINGUNO}, ANCHO and ANCHO_DIR defaults.
//  - Sub-module decodificador_inmediato: combinational, instr -> {tipo_inm_t, imm, usa_rs1, usa_rs2}.
//  - Top level: operand mux, hazard logic, handshake, ID/EX register.
// TESTING
//  - Reset low mid-stream -> out_valid=0, out_op1=0 and out_imm=0 asynchronously; in_ready=1 after release.
//  - ADDI x5,x1,-3 (0xFFD08293), Op1=10, out_ready=1 -> next cycle out_op1=10, out_imm=0xFFFFFFFD, out_rd=5, out_rd_we=1.
//  - ADD x3,x1,x2 with wb_we=1, wb_de=2, wb_dato=0x55, Op2=0x11 -> out_op2=0x55; with DL1=0 operand -> 0.
//  - ex_load=1, ex_rd=1, ADD x3,x1,x2 presented, out_ready=1 -> in_ready=0, one bubble, accepted next cycle.
//  - out_ready=0 for 3 cycles with out_valid=1 -> outputs constant, in_ready=0; then 1 -> next instruction accepted.
//  - flush=1 with in_valid=1 and out_valid=1 -> next cycle out_valid=0; the presented instruction never appears.

Source files
------------

// File: rtl/etapa_decodificacion_pkg.sv
// +----------------------------------------------------------------------------+
// | isa_pkg : RV32I opcodes, immediate kinds and default widths for decode.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package isa_pkg;

  localparam int ANCHO_DEF     = 32;
  localparam int ANCHO_DIR_DEF = 5;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    INM_I,
    INM_S,
    INM_B,
    INM_U,
    INM_J,
    INM_NINGUNO
  } tipo_inm_t;

endpackage

`default_nettype wire

// File: rtl/etapa_decodificacion_inmediato.sv
// +----------------------------------------------------------------------------+
// | decodificador_inmediato : opcode -> immediate format, value, source usage. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module decodificador_inmediato
  import isa_pkg::*;
(
  input  logic [31:0] instr_i,
  output tipo_inm_t   tipo_o,
  output logic [31:0] imm_o,
  output logic        usa_rs1_o,
  output logic        usa_rs2_o
);

  logic [6:0] w_opcode;
  assign w_opcode = instr_i[6:0];

  always_comb begin
    tipo_o    = INM_NINGUNO;
    usa_rs1_o = 1'b1;
    usa_rs2_o = 1'b0;
    case (w_opcode)
      OP:                 usa_rs2_o = 1'b1;
      OP_IMM, LOAD, JALR: tipo_o    = INM_I;
      STORE: begin
        tipo_o    = INM_S;
        usa_rs2_o = 1'b1;
      end
      BRANCH: begin
        tipo_o    = INM_B;
        usa_rs2_o = 1'b1;
      end
      LUI, AUIPC: begin
        tipo_o    = INM_U;
        usa_rs1_o = 1'b0;
      end
      JAL: begin
        tipo_o    = INM_J;
        usa_rs1_o = 1'b0;
      end
      default: ;
    endcase
  end

  always_comb begin
    imm_o = '0;
    case (tipo_o)
      INM_I: imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
      INM_S: imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      INM_B: imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                      instr_i[30:25], instr_i[11:8], 1'b0};
      INM_U: imm_o = {instr_i[31:12], 12'b0};
      INM_J: imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                      instr_i[20], instr_i[30:21], 1'b0};
      default: imm_o = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/etapa_decodificacion.sv
// +----------------------------------------------------------------------------+
// | etapa_decodificacion : RV32I decode / operand fetch with ID/EX register.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module etapa_decodificacion
  import isa_pkg::*;
#(
  parameter int ANCHO     = ANCHO_DEF,
  parameter int ANCHO_DIR = ANCHO_DIR_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ANCHO-1:0]     in_instr,
  input  logic [ANCHO-1:0]     in_pc,
  input  logic                 flush,
  output logic [ANCHO_DIR-1:0] DL1,
  output logic [ANCHO_DIR-1:0] DL2,
  input  logic [ANCHO-1:0]     Op1,
  input  logic [ANCHO-1:0]     Op2,
  input  logic                 wb_we,
  input  logic [ANCHO_DIR-1:0] wb_de,
  input  logic [ANCHO-1:0]     wb_dato,
  input  logic                 ex_load,
  input  logic [ANCHO_DIR-1:0] ex_rd,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ANCHO-1:0]     out_op1,
  output logic [ANCHO-1:0]     out_op2,
  output logic [ANCHO-1:0]     out_imm,
  output logic [ANCHO_DIR-1:0] out_rd,
  output logic                 out_rd_we,
  output logic [6:0]           out_opcode,
  output logic [2:0]           out_funct3,
  output logic                 out_funct7b5,
  output logic [ANCHO-1:0]     out_pc
);

  logic [ANCHO_DIR-1:0] rs1, rs2, rd;
  logic [6:0]           opcode;
  tipo_inm_t            tipo;
  logic [ANCHO-1:0]     imm;
  logic                 usa_rs1, usa_rs2;
  logic                 hazard, accept;

  logic [ANCHO-1:0]     op1_d, op2_d;
  logic                 rd_we_d;

  logic                 valid_q;
  logic [ANCHO-1:0]     op1_q, op2_q, imm_q, pc_q;
  logic [ANCHO_DIR-1:0] rd_q;
  logic                 rd_we_q;
  logic [6:0]           opcode_q;
  logic [2:0]           funct3_q;
  logic                 funct7b5_q;

  assign rs1    = in_instr[19:15];
  assign rs2    = in_instr[24:20];
  assign rd     = in_instr[11:7];
  assign opcode = in_instr[6:0];
  assign DL1    = rs1;
  assign DL2    = rs2;

  decodificador_inmediato u_inm (
    .instr_i   (in_instr),
    .tipo_o    (tipo),
    .imm_o     (imm),
    .usa_rs1_o (usa_rs1),
    .usa_rs2_o (usa_rs2)
  );

  // x0 wins over the bypass so a write-back to x0 can never leak a value
  always_comb begin
    op1_d = Op1;
    if (rs1 == '0)                  op1_d = '0;
    else if (wb_we && wb_de == rs1) op1_d = wb_dato;
    op2_d = Op2;
    if (rs2 == '0)                  op2_d = '0;
    else if (wb_we && wb_de == rs2) op2_d = wb_dato;
  end

  assign rd_we_d = (rd != '0) &&
                   ((opcode == OP) || (tipo == INM_I) ||
                    (tipo == INM_U) || (tipo == INM_J));

  assign hazard = ex_load && (ex_rd != '0) &&
                  ((usa_rs1 && rs1 == ex_rd) || (usa_rs2 && rs2 == ex_rd));

  assign in_ready = (!valid_q || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      op1_q      <= '0;
      op2_q      <= '0;
      imm_q      <= '0;
      pc_q       <= '0;
      rd_q       <= '0;
      rd_we_q    <= 1'b0;
      opcode_q   <= '0;
      funct3_q   <= '0;
      funct7b5_q <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q    <= 1'b1;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      imm_q      <= imm;
      pc_q       <= in_pc;
      rd_q       <= rd;
      rd_we_q    <= rd_we_d;
      opcode_q   <= opcode;
      funct3_q   <= in_instr[14:12];
      funct7b5_q <= in_instr[30];
    end else if (out_ready && valid_q) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid    = valid_q;
  assign out_op1      = op1_q;
  assign out_op2      = op2_q;
  assign out_imm      = imm_q;
  assign out_pc       = pc_q;
  assign out_rd       = rd_q;
  assign out_rd_we    = rd_we_q;
  assign out_opcode   = opcode_q;
  assign out_funct3   = funct3_q;
  assign out_funct7b5 = funct7b5_q;

endmodule

`default_nettype wire

// File: tb/tb_etapa_decodificacion.sv
// +----------------------------------------------------------------------------+
// | tb_etapa_decodificacion : scoreboard bench for the decode stage.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_etapa_decodificacion;

  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        rd_we;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        f7b5;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, flush;
  logic [31:0] in_instr, in_pc, Op1, Op2, wb_dato;
  logic [4:0]  DL1, DL2, wb_de, ex_rd;
  logic        wb_we, ex_load;
  logic        out_valid, out_ready;
  logic [31:0] out_op1, out_op2, out_imm, out_pc;
  logic [4:0]  out_rd;
  logic        out_rd_we;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3;
  logic        out_funct7b5;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];
  exp_t mon_e;

  etapa_decodificacion dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush), .DL1(DL1), .DL2(DL2), .Op1(Op1), .Op2(Op2),
    .wb_we(wb_we), .wb_de(wb_de), .wb_dato(wb_dato),
    .ex_load(ex_load), .ex_rd(ex_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op1(out_op1), .out_op2(out_op2), .out_imm(out_imm), .out_rd(out_rd),
    .out_rd_we(out_rd_we), .out_opcode(out_opcode), .out_funct3(out_funct3),
    .out_funct7b5(out_funct7b5), .out_pc(out_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] op1, op2, imm, pc, input logic [4:0] rd,
                              input logic we, input logic [6:0] opc, input logic [2:0] f3,
                              input logic f7b5);
    exp_t e;
    e.op1 = op1; e.op2 = op2; e.imm = imm; e.pc = pc; e.rd = rd;
    e.rd_we = we; e.opc = opc; e.f3 = f3; e.f7b5 = f7b5;
    return e;
  endfunction

  // Monitor: every consumed ID/EX entry must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready && !flush) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output: actual pc=%h required=no output", out_pc);
      end else begin
        mon_e = sb.pop_front();
        chk("out_op1",   out_op1,             mon_e.op1);
        chk("out_op2",   out_op2,             mon_e.op2);
        chk("out_imm",   out_imm,             mon_e.imm);
        chk("out_pc",    out_pc,              mon_e.pc);
        chk("out_rd",    {27'b0, out_rd},     {27'b0, mon_e.rd});
        chk("out_rd_we", {31'b0, out_rd_we},  {31'b0, mon_e.rd_we});
        chk("out_opcode",{25'b0, out_opcode}, {25'b0, mon_e.opc});
        chk("out_funct3",{29'b0, out_funct3}, {29'b0, mon_e.f3});
        chk("out_f7b5",  {31'b0, out_funct7b5}, {31'b0, mon_e.f7b5});
      end
    end
  end

  task automatic send(input logic [31:0] instr, pc, op1v, op2v, input exp_t e, input bit push);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    Op1      = op1v;
    Op2      = op2v;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: actual in_ready=0 required=1 pc=%h", pc);
    end else if (push) begin
      sb.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; in_instr = '0; in_pc = '0;
    Op1 = '0; Op2 = '0; wb_we = 1'b0; wb_de = '0; wb_dato = '0;
    ex_load = 1'b0; ex_rd = '0; out_ready = 1'b1;

    idle(2);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_op1",   out_op1, 32'd0);
    chk("rst_out_imm",   out_imm, 32'd0);
    chk("rst_out_pc",    out_pc,  32'd0);
    chk("rst_in_ready",  {31'b0, in_ready}, 32'd1);
    rst_n = 1'b1;
    idle(1);

    // ADDI x5,x1,-3; a load into x29 matches only the unused rs2 field
    ex_load = 1'b1; ex_rd = 5'd29;
    in_instr = 32'hFFD08293;
    #1;
    chk("DL1", {27'b0, DL1}, 32'd1);
    chk("DL2", {27'b0, DL2}, 32'd29);
    send(32'hFFD08293, 32'h100, 32'd10, 32'h77,
         mk(32'd10, 32'h77, 32'hFFFFFFFD, 32'h100, 5'd5, 1'b1, 7'h13, 3'd0, 1'b1), 1'b1);
    ex_load = 1'b0; ex_rd = '0;

    // ADD x3,x1,x2 with write-back bypass on x2
    wb_we = 1'b1; wb_de = 5'd2; wb_dato = 32'h55;
    send(32'h002081B3, 32'h104, 32'h10, 32'h11,
         mk(32'h10, 32'h55, 32'h0, 32'h104, 5'd3, 1'b1, 7'h33, 3'd0, 1'b0), 1'b1);
    // ADD x3,x0,x2 with a write-back to x0 that must not be forwarded
    wb_de = 5'd0;
    send(32'h002001B3, 32'h108, 32'h99, 32'h11,
         mk(32'h0, 32'h11, 32'h0, 32'h108, 5'd3, 1'b1, 7'h33, 3'd0, 1'b0), 1'b1);
    wb_we = 1'b0;

    send(32'hFE20AE23, 32'h10C, 32'hA1, 32'hA2,
         mk(32'hA1, 32'hA2, 32'hFFFFFFFC, 32'h10C, 5'd28, 1'b0, 7'h23, 3'd2, 1'b1), 1'b1);
    send(32'h00208463, 32'h110, 32'hB1, 32'hB2,
         mk(32'hB1, 32'hB2, 32'h8, 32'h110, 5'd8, 1'b0, 7'h63, 3'd0, 1'b0), 1'b1);
    // LUI does not read rs1, so a load into its rs1 field does not stall
    ex_load = 1'b1; ex_rd = 5'd8;
    send(32'h123453B7, 32'h114, 32'hA, 32'hB,
         mk(32'hA, 32'hB, 32'h12345000, 32'h114, 5'd7, 1'b1, 7'h37, 3'd5, 1'b0), 1'b1);
    ex_load = 1'b0; ex_rd = '0;
    send(32'h010000EF, 32'h118, 32'hC1, 32'hC2,
         mk(32'h0, 32'hC2, 32'h10, 32'h118, 5'd1, 1'b1, 7'h6F, 3'd0, 1'b0), 1'b1);
    send(32'h00000FFF, 32'h11C, 32'hD1, 32'hD2,
         mk(32'h0, 32'h0, 32'h0, 32'h11C, 5'd31, 1'b0, 7'h7F, 3'd0, 1'b0), 1'b1);

    // Load-use hazard on x1
    ex_load = 1'b1; ex_rd = 5'd1;
    in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h200; Op1 = 32'h20; Op2 = 32'h21;
    @(negedge clk);
    chk("hazard_in_ready", {31'b0, in_ready}, 32'd0);
    @(posedge clk); #1;
    ex_load = 1'b0; Op1 = 32'h30;
    @(negedge clk);
    chk("hazard_bubble", {31'b0, out_valid}, 32'd0);
    chk("hazard_release_in_ready", {31'b0, in_ready}, 32'd1);
    sb.push_back(mk(32'h30, 32'h21, 32'h0, 32'h200, 5'd3, 1'b1, 7'h33, 3'd0, 1'b0));
    @(posedge clk); #1;
    in_valid = 1'b0;
    idle(2);

    // Backpressure for 3 cycles
    out_ready = 1'b0;
    send(32'hFFD08293, 32'h300, 32'd5, 32'd0,
         mk(32'd5, 32'd0, 32'hFFFFFFFD, 32'h300, 5'd5, 1'b1, 7'h13, 3'd0, 1'b1), 1'b1);
    in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h304; Op1 = 32'd1; Op2 = 32'd2;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("stall_in_ready",  {31'b0, in_ready},  32'd0);
      chk("stall_out_valid", {31'b0, out_valid}, 32'd1);
      chk("stall_out_op1",   out_op1, 32'd5);
      chk("stall_out_imm",   out_imm, 32'hFFFFFFFD);
      chk("stall_out_pc",    out_pc,  32'h300);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("unstall_in_ready", {31'b0, in_ready}, 32'd1);
    sb.push_back(mk(32'd1, 32'd2, 32'h0, 32'h304, 5'd3, 1'b1, 7'h33, 3'd0, 1'b0));
    @(posedge clk); #1;
    in_valid = 1'b0;
    idle(2);

    // Flush drops both the held and the presented instruction
    out_ready = 1'b0;
    send(32'h00208463, 32'h400, 32'd3, 32'd4, mk('0, '0, '0, '0, '0, 1'b0, '0, '0, 1'b0), 1'b0);
    in_valid = 1'b1; in_instr = 32'h123453B7; in_pc = 32'h404; flush = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
    idle(3);

    // Asynchronous reset while an instruction is held
    out_ready = 1'b0;
    send(32'hFFD08293, 32'h500, 32'd7, 32'd0, mk('0, '0, '0, '0, '0, 1'b0, '0, '0, 1'b0), 1'b0);
    chk("pre_reset_out_valid", {31'b0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("async_rst_out_op1",   out_op1, 32'd0);
    chk("async_rst_out_imm",   out_imm, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
    idle(2);

    chk("scoreboard_left", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
